// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and status/control bit positions.
package uart_tx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } utx_state_t;

    localparam logic [1:0] UTX_DATA = 2'b00;
    localparam logic [1:0] UTX_CTRL = 2'b10;

    localparam int BUSY = 0;
    localparam int FULL = 1;
    localparam int OVF  = 2;
    localparam int PAR  = 3;

    localparam int CTRL_OVF_CLR = 2;

endpackage

// File: rtl/utx_fifo.sv
// Single-clock byte FIFO with wrap-bit pointers; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module utx_fifo #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped 8N1 UART transmitter on the CPU I/O bus.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx_io
    import uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 23_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        utx_clk,
    input  logic        utxrst,
    input  logic        utxwrite,
    input  logic        utxread,
    input  logic        utxcs,
    input  logic [1:0]  utxaddr,
    input  logic [15:0] utxwdata,
    output logic [15:0] utxrdata,
    output logic        tx
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    utx_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bitidx;
    logic [7:0]       shift;
    logic             ovf;
    logic             full;
    logic             empty;
    logic             busy;
    logic             pop;
    logic             push_req;
    logic             ovf_clr;
    logic             bit_end;
    logic [7:0]       fifo_rdata;
    logic             wdata_unused;
`ifdef UART_TX_PARITY_EN
    logic             par_bit;
`endif

    assign wdata_unused = ^utxwdata[15:8];
    assign push_req = utxwrite && utxcs && (utxaddr == UTX_DATA);
    assign ovf_clr  = utxwrite && utxcs && (utxaddr == UTX_CTRL) && utxwdata[CTRL_OVF_CLR];
    assign bit_end  = (cnt == CNT_MAX);
    assign busy     = (state != S_IDLE) || !empty;
    // A new byte is taken from idle, or straight from the end of a stop bit.
    assign pop      = !empty && ((state == S_IDLE) || (state == S_STOP && bit_end));

    utx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .DATA_W(8)
    ) u_fifo (
        .clk  (utx_clk),
        .rst  (utxrst),
        .push (push_req),
        .pop  (pop),
        .wdata(utxwdata[7:0]),
        .rdata(fifo_rdata),
        .full (full),
        .empty(empty)
    );

    always_ff @(posedge utx_clk) begin
        if (pop) begin
            shift <= fifo_rdata;
        end else if (state == S_DATA && bit_end) begin
            shift <= shift >> 1;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge utx_clk) begin
        if (pop) par_bit <= ^fifo_rdata;
    end
`endif

    always_ff @(posedge utx_clk) begin
        if (utxrst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            bitidx <= '0;
            tx     <= 1'b1;
            ovf    <= 1'b0;
        end else begin
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        state <= S_START;
                        cnt   <= '0;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state  <= S_DATA;
                        cnt    <= '0;
                        bitidx <= '0;
                        tx     <= shift[0];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (bitidx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx    <= par_bit;
`else
                            state <= S_STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bitidx <= bitidx + 3'd1;
                            tx     <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state <= S_STOP;
                        cnt   <= '0;
                        tx    <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (!empty) begin
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        utxrdata = 16'h0000;
        if (utxread && utxcs) begin
            utxrdata[BUSY] = busy;
            utxrdata[FULL] = full;
            utxrdata[OVF]  = ovf;
            utxrdata[PAR]  = PAR_EN;
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// Directed bench for uart_tx_io with DIV = 8 and a 4-entry FIFO; honours
// UART_TX_PARITY_EN for the frame length and status bit 3.
module tb_uart_tx_io;

`ifdef UART_TX_PARITY_EN
    localparam int          FL    = 88;
    localparam logic [15:0] STAT0 = 16'h0008;
`else
    localparam int          FL    = 80;
    localparam logic [15:0] STAT0 = 16'h0000;
`endif

    logic        fpga_clk = 1'b0;
    logic        rst;
    logic        wr;
    logic        rd;
    logic        cs;
    logic [1:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        tx;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int   k;
        logic tx;
        logic busy;
    } vec_t;

    vec_t tbl[$];

    always #5 fpga_clk = ~fpga_clk;

    uart_tx_io #(
        .CLK_HZ    (8),
        .BAUD      (1),
        .FIFO_DEPTH(4)
    ) dut (
        .utx_clk (fpga_clk),
        .utxrst  (rst),
        .utxwrite(wr),
        .utxread (rd),
        .utxcs   (cs),
        .utxaddr (addr),
        .utxwdata(wdata),
        .utxrdata(rdata),
        .tx      (tx)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        wr    = 1'b0;
    endtask

    initial begin
        int idx;
        int low_cnt;

        // Single-frame expectations for 8'hA5, k = cycles after the write cycle.
        tbl.push_back('{1,  1'b1, 1'b1});
        tbl.push_back('{2,  1'b0, 1'b1});
        tbl.push_back('{9,  1'b0, 1'b1});
        tbl.push_back('{10, 1'b1, 1'b1});
        tbl.push_back('{17, 1'b1, 1'b1});
        tbl.push_back('{18, 1'b0, 1'b1});
        tbl.push_back('{26, 1'b1, 1'b1});
        tbl.push_back('{34, 1'b0, 1'b1});
        tbl.push_back('{42, 1'b0, 1'b1});
        tbl.push_back('{50, 1'b1, 1'b1});
        tbl.push_back('{58, 1'b0, 1'b1});
        tbl.push_back('{66, 1'b1, 1'b1});
        tbl.push_back('{73, 1'b1, 1'b1});
`ifdef UART_TX_PARITY_EN
        tbl.push_back('{74, 1'b0, 1'b1});
        tbl.push_back('{81, 1'b0, 1'b1});
        tbl.push_back('{82, 1'b1, 1'b1});
        tbl.push_back('{89, 1'b1, 1'b1});
        tbl.push_back('{90, 1'b1, 1'b0});
`else
        tbl.push_back('{74, 1'b1, 1'b1});
        tbl.push_back('{81, 1'b1, 1'b1});
        tbl.push_back('{82, 1'b1, 1'b0});
`endif

        rst   = 1'b1;
        wr    = 1'b0;
        rd    = 1'b1;
        cs    = 1'b1;
        addr  = 2'b00;
        wdata = 16'h0000;
        tick();
        tick();
        check("reset_tx", 16'(tx), 16'h0001);
        check("reset_status", rdata, STAT0);
        rst = 1'b0;
        tick();
        cs = 1'b0;
        #1;
        check("unselected_read", rdata, 16'h0000);
        cs = 1'b1;
        rd = 1'b0;
        #1;
        check("no_read_strobe", rdata, 16'h0000);
        rd = 1'b1;
        tick();

        // Single frame
        bus_write(2'b00, 16'h00A5);
        idx = 0;
        for (int k = 1; idx < tbl.size(); k++) begin
            while (idx < tbl.size() && tbl[idx].k == k) begin
                check($sformatf("frame_a5_tx_k%0d", k), 16'(tx), 16'(tbl[idx].tx));
                check($sformatf("frame_a5_busy_k%0d", k), 16'(rdata[0]), 16'(tbl[idx].busy));
                idx++;
            end
            tick();
        end
        repeat (4) tick();

        // Back-to-back frames
        bus_write(2'b00, 16'h0001);
        bus_write(2'b00, 16'h0002);
        for (int k = 2; k <= 2 * FL + 2; k++) begin
            if (k == 2)          check("b2b_start1", 16'(tx), 16'h0000);
            if (k == 10)         check("b2b_bit0_of_01", 16'(tx), 16'h0001);
            if (k == FL + 1)     check("b2b_stop1_last", 16'(tx), 16'h0001);
            if (k == FL + 2)     check("b2b_start2_first", 16'(tx), 16'h0000);
            if (k == FL + 9)     check("b2b_start2_last", 16'(tx), 16'h0000);
            if (k == FL + 10)    check("b2b_bit0_of_02", 16'(tx), 16'h0000);
            if (k == FL + 18)    check("b2b_bit1_of_02", 16'(tx), 16'h0001);
            if (k == 2 * FL + 1) check("b2b_busy_end", 16'(rdata[0]), 16'h0001);
            if (k == 2 * FL + 2) check("b2b_idle", 16'(rdata[0]), 16'h0000);
            tick();
        end
        repeat (4) tick();

        // Overflow: six writes, one popped, four held, sixth dropped
        for (int i = 0; i < 6; i++) bus_write(2'b00, 16'h0011 + 16'(i));
        check("ovf_status", rdata, STAT0 | 16'h0007);
        bus_write(2'b10, 16'h0004);
        check("ovf_cleared_full", rdata, STAT0 | 16'h0003);
        repeat (FL + 1 - 7) tick();
        // Push lands in the same cycle as the pop at the end of the first frame
        bus_write(2'b00, 16'h0077);
        check("push_pop_on_full", rdata, STAT0 | 16'h0003);
        check("second_frame_start", 16'(tx), 16'h0000);

        // Reset mid-frame, with a push in the reset cycle
        repeat (20) tick();
        rst   = 1'b1;
        wr    = 1'b1;
        addr  = 2'b00;
        wdata = 16'h0099;
        tick();
        rst = 1'b0;
        wr  = 1'b0;
        check("midrst_tx", 16'(tx), 16'h0001);
        check("midrst_status", rdata, STAT0);
        low_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (tx !== 1'b1) low_cnt++;
            tick();
        end
        check("midrst_no_frame", 16'(low_cnt), 16'h0000);
        check("midrst_idle_status", rdata, STAT0);

`ifdef UART_TX_PARITY_EN
        bus_write(2'b00, 16'h0007);
        check("par_status_bit3", 16'(rdata[3]), 16'h0001);
        for (int k = 1; k <= 90; k++) begin
            if (k == 73) check("par_bit7", 16'(tx), 16'h0000);
            if (k == 74) check("par_bit_first", 16'(tx), 16'h0001);
            if (k == 81) check("par_bit_last", 16'(tx), 16'h0001);
            if (k == 82) check("par_stop", 16'(tx), 16'h0001);
            if (k == 89) check("par_busy_end", 16'(rdata[0]), 16'h0001);
            if (k == 90) check("par_idle", 16'(rdata[0]), 16'h0000);
            tick();
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
